// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone ROM arbiter.
// Grant states, master-select encoding and default bus geometry.
package wb_arb_pkg;

  localparam int unsigned AW_DEF      = 10;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } msel_e;

  function automatic arb_state_e state_for(input msel_e m);
    return (m == SEL_M1) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Two-request round-robin picker: a tie goes to the master not served last.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output msel_e      o_winner,
  output logic       o_valid
);

  // Winner selection from the request pair and last-served master
  always_comb begin
    o_winner = SEL_M0;
    o_valid  = 1'b0;
    case (i_req)
      2'b01: begin
        o_winner = SEL_M0;
        o_valid  = 1'b1;
      end
      2'b10: begin
        o_winner = SEL_M1;
        o_valid  = 1'b1;
      end
      2'b11: begin
        o_winner = i_last ? SEL_M0 : SEL_M1;
        o_valid  = 1'b1;
      end
      default: begin
        o_winner = SEL_M0;
        o_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wishbone_rom_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the shared ROM: round-robin
// grant held for the bus cycle, with a per-transfer ack watchdog.
module wishbone_rom_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_addr_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_last;
  logic       w_next_last;
  logic [7:0] r_wd;
  msel_e      w_pick;
  logic       w_pick_valid;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_stb;
  logic       w_timeout;

  wb_rr_pick u_pick (
    .i_req    ({m1_cyc_i, m0_cyc_i}),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  // Grant state and last-served master
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
    end
  end

  // Grant decisions; releases always pass through IDLE to swallow stray acks
  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next_state = state_for(w_pick);
        end else begin
          w_next_state = IDLE;
        end
      end
      GNT0: begin
        if (m0_cyc_i) begin
          w_next_state = GNT0;
        end else begin
          w_next_state = IDLE;
          w_next_last  = 1'b0;
        end
      end
      GNT1: begin
        if (m1_cyc_i) begin
          w_next_state = GNT1;
        end else begin
          w_next_state = IDLE;
          w_next_last  = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_last  = r_last;
      end
    endcase
  end

  // Grants are masked while reset is asserted so every output is quiet then
  assign w_gnt0 = (r_state == GNT0) && !rst_i;
  assign w_gnt1 = (r_state == GNT1) && !rst_i;

  // Forwarding muxes toward the slave and read-data return to the masters
  always_comb begin
    s_cyc_o  = 1'b0;
    w_stb    = 1'b0;
    s_sel_o  = 4'h0;
    s_addr_o = {AW{1'b0}};
    m0_dat_o = {DW{1'b0}};
    m1_dat_o = {DW{1'b0}};
    if (w_gnt0) begin
      s_cyc_o  = m0_cyc_i;
      w_stb    = m0_cyc_i & m0_stb_i;
      s_sel_o  = m0_sel_i;
      s_addr_o = m0_addr_i;
      m0_dat_o = s_dat_i;
    end else if (w_gnt1) begin
      s_cyc_o  = m1_cyc_i;
      w_stb    = m1_cyc_i & m1_stb_i;
      s_sel_o  = m1_sel_i;
      s_addr_o = m1_addr_i;
      m1_dat_o = s_dat_i;
    end else begin
      s_cyc_o  = 1'b0;
      w_stb    = 1'b0;
    end
  end

  assign s_stb_o   = w_stb;
  assign s_dat_o   = {DW{1'b0}};
  assign w_timeout = w_stb & ~s_ack_i & (r_wd == WD_LIMIT);
  assign m0_ack_o  = w_gnt0 & s_ack_i;
  assign m1_ack_o  = w_gnt1 & s_ack_i;
  assign m0_err_o  = w_gnt0 & w_timeout;
  assign m1_err_o  = w_gnt1 & w_timeout;

  // Watchdog: counts cycles of an unacknowledged strobe, restarts on expiry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd <= 8'd0;
    end else if (!w_stb || s_ack_i || w_timeout) begin
      r_wd <= 8'd0;
    end else begin
      r_wd <= r_wd + 8'd1;
    end
  end

endmodule

// File: tb/tb_wishbone_rom_arbiter.sv
// Self-checking bench for wishbone_rom_arbiter with a one-cycle ROM slave model.
module tb_wishbone_rom_arbiter;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_ack_i;

  logic          slv_ack_r;
  logic [DW-1:0] slv_dat_r;
  logic          ack_en;
  logic          force_ack;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_m;
  logic [DW-1:0] mon_d, mon_other;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  wishbone_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {6'h2B, a, ~a, 6'h15};
  endfunction

  // ROM slave: registered ack, dropped for one cycle between transfers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slv_ack_r <= 1'b0;
      slv_dat_r <= '0;
    end else begin
      slv_ack_r <= s_stb_o & ~slv_ack_r & ack_en;
      slv_dat_r <= rom_word(s_addr_o);
    end
  end
  assign s_ack_i = slv_ack_r | force_ack;
  assign s_dat_i = slv_dat_r;

  // Scoreboard: every master ack pops the next expected (master, data) pair
  always @(negedge clk_i) begin
    if (m0_ack_o || m1_ack_o) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL ack_unexpected: m0_ack=%0b m1_ack=%0b, required no ack", m0_ack_o, m1_ack_o);
      end else begin
        mon_e     = exp_q.pop_front();
        mon_m     = m1_ack_o;
        mon_d     = mon_m ? m1_dat_o : m0_dat_o;
        mon_other = mon_m ? m0_dat_o : m1_dat_o;
        if ((m0_ack_o && m1_ack_o) || mon_m !== mon_e.m || mon_d !== mon_e.d ||
            mon_other !== '0 || m0_err_o || m1_err_o) begin
          $display("FAIL ack_data: got m%0d dat=%h other=%h, required m%0d dat=%h other=0",
                   mon_m, mon_d, mon_other, mon_e.m, mon_e.d);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_sel_i = 4'h0; m0_addr_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_sel_i = 4'h0; m1_addr_i = '0;
  endtask

  task automatic push_exp(input logic m, input logic [AW-1:0] a);
    exp_t e;
    e.m = m;
    e.d = rom_word(a);
    exp_q.push_back(e);
  endtask

  task automatic req(input logic m, input logic [AW-1:0] a);
    if (m) begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_sel_i = 4'hF; m1_addr_i = a;
    end else begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_sel_i = 4'hF; m0_addr_i = a;
    end
  endtask

  task automatic drop(input logic m);
    if (m) begin
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    end else begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    end
  endtask

  // Leaves the caller at the start of cycle 0: reset released, one idle cycle passed
  task automatic apply_reset();
    rst_i = 1'b1; ack_en = 1'b1; force_ack = 1'b0;
    idle_masters();
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
  endtask

  // Waits at negedges for any master ack; got=0 when the budget expires
  task automatic wait_any_ack(output logic got);
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (m0_ack_o || m1_ack_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic outs_zero();
    return !(s_cyc_o || s_stb_o || (|s_sel_o) || (|s_addr_o) || (|s_dat_o) ||
             m0_ack_o || m1_ack_o || m0_err_o || m1_err_o || (|m0_dat_o) || (|m1_dat_o));
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; ack_en = 1'b1; force_ack = 1'b0;
    req(1'b0, 10'h3FF); req(1'b1, 10'h155);
    repeat (2) tick();
    @(negedge clk_i);
    n_total++;
    if (outs_zero() !== 1'b1) $display("FAIL reset_during: s_cyc=%0b s_stb=%0b, required all outputs 0", s_cyc_o, s_stb_o);
    else n_pass++;
    tick();
    rst_i = 1'b0;
    idle_masters();
    @(negedge clk_i);
    n_total++;
    if (outs_zero() !== 1'b1) $display("FAIL reset_after: s_cyc=%0b s_addr=%h, required all outputs 0", s_cyc_o, s_addr_o);
    else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    req(1'b0, 10'h004);
    push_exp(1'b0, 10'h004);
    @(negedge clk_i);
    n_total++;
    if (s_stb_o !== 1'b0) $display("FAIL single_c0_stb: s_stb=%0b, required 0", s_stb_o);
    else n_pass++;
    tick();
    @(negedge clk_i);
    n_total++;
    if (s_stb_o !== 1'b1 || s_addr_o !== 10'h004 || s_sel_o !== 4'hF)
      $display("FAIL single_c1_fwd: stb=%0b addr=%h sel=%h, required 1 004 f", s_stb_o, s_addr_o, s_sel_o);
    else n_pass++;
    tick();
    @(negedge clk_i);
    n_total++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || m1_dat_o !== '0)
      $display("FAIL single_c2_ack: m0_ack=%0b m1_ack=%0b m1_dat=%h, required 1 0 0", m0_ack_o, m1_ack_o, m1_dat_o);
    else n_pass++;
    tick();
    idle_masters();
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req(1'b0, 10'h005); req(1'b1, 10'h006);
    push_exp(1'b0, 10'h005); push_exp(1'b1, 10'h006);
    tick();
    @(negedge clk_i);
    n_total++;
    if (s_addr_o !== 10'h005 || s_stb_o !== 1'b1) $display("FAIL simul_first: addr=%h stb=%0b, required 005 1", s_addr_o, s_stb_o);
    else n_pass++;
    tick();
    tick();
    drop(1'b0);
    tick();
    @(negedge clk_i);
    n_total++;
    if (s_cyc_o !== 1'b0) $display("FAIL simul_idle: s_cyc=%0b, required 0", s_cyc_o);
    else n_pass++;
    tick();
    @(negedge clk_i);
    n_total++;
    if (s_stb_o !== 1'b1 || s_addr_o !== 10'h006) $display("FAIL simul_gnt1: stb=%0b addr=%h, required 1 006", s_stb_o, s_addr_o);
    else n_pass++;
    tick();
    @(negedge clk_i);
    n_total++;
    if (m1_ack_o !== 1'b1) $display("FAIL simul_m1_ack: m1_ack=%0b, required 1", m1_ack_o);
    else n_pass++;
    tick();
    idle_masters();
    repeat (2) tick();
  endtask

  task automatic test_fairness();
    logic got;
    apply_reset();
    req(1'b0, 10'h030); req(1'b1, 10'h040);
    for (int k = 0; k < 8; k++) push_exp(k[0], k[0] ? 10'h040 : 10'h030);
    for (int k = 0; k < 8; k++) begin
      wait_any_ack(got);
      n_total++;
      if (!got || m1_ack_o !== k[0]) $display("FAIL fair_order_%0d: got=%0b m1_ack=%0b, required ack from m%0d", k, got, m1_ack_o, k[0]);
      else n_pass++;
      tick();
      drop(k[0]);
      tick();
      req(k[0], k[0] ? 10'h040 : 10'h030);
      @(negedge clk_i);
      n_total++;
      if (s_cyc_o !== 1'b0) $display("FAIL fair_idle_%0d: s_cyc=%0b, required 0", k, s_cyc_o);
      else n_pass++;
      if (!got) break;
    end
    tick();
    idle_masters();
    repeat (3) tick();
    exp_q.delete();
  endtask

  task automatic test_lock();
    logic got;
    apply_reset();
    req(1'b0, 10'h010); req(1'b1, 10'h050);
    for (int j = 0; j < 3; j++) push_exp(1'b0, 10'(10'h010 + j));
    push_exp(1'b1, 10'h050);
    for (int j = 0; j < 3; j++) begin
      wait_any_ack(got);
      n_total++;
      if (!got || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0)
        $display("FAIL lock_m0_%0d: got=%0b m0_ack=%0b m1_ack=%0b, required 1 1 0", j, got, m0_ack_o, m1_ack_o);
      else n_pass++;
      tick();
      if (j < 2) m0_addr_i = 10'(10'h011 + j);
      else drop(1'b0);
    end
    wait_any_ack(got);
    n_total++;
    if (!got || m1_ack_o !== 1'b1) $display("FAIL lock_m1: got=%0b m1_ack=%0b, required 1 1", got, m1_ack_o);
    else n_pass++;
    tick();
    idle_masters();
    repeat (2) tick();
  endtask

  task automatic test_watchdog();
    int   err_cnt = 0;
    int   err_at  = -1;
    logic m0_err_seen = 1'b0;
    logic seen_stb = 1'b0;
    apply_reset();
    ack_en = 1'b0;
    req(1'b1, 10'h007);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (s_stb_o) begin
        seen_stb = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen_stb) $display("FAIL wd_stb_timeout: s_stb=%0b, required 1 within budget", s_stb_o);
    else n_pass++;
    for (int n = 0; n < 25; n++) begin
      if (n > 0) @(negedge clk_i);
      if (m1_err_o) begin
        err_cnt++;
        if (err_at < 0) err_at = n;
      end
      if (m0_err_o) m0_err_seen = 1'b1;
    end
    n_total++;
    if (err_cnt !== 1 || err_at !== TIMEOUT - 1)
      $display("FAIL wd_pulse: count=%0d at=%0d, required count=1 at=%0d", err_cnt, err_at, TIMEOUT - 1);
    else n_pass++;
    n_total++;
    if (m0_err_seen !== 1'b0 || s_cyc_o !== 1'b1 || s_addr_o !== 10'h007)
      $display("FAIL wd_hold: m0_err=%0b s_cyc=%0b addr=%h, required 0 1 007", m0_err_seen, s_cyc_o, s_addr_o);
    else n_pass++;
    tick();
    idle_masters();
    ack_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    logic got;
    apply_reset();
    ack_en = 1'b0;
    req(1'b0, 10'h008);
    tick();
    tick();
    drop(1'b0);
    tick();
    force_ack = 1'b1;
    req(1'b1, 10'h009);
    push_exp(1'b1, 10'h009);
    @(negedge clk_i);
    n_total++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0)
      $display("FAIL abort_stale: m0_ack=%0b m1_ack=%0b s_cyc=%0b, required 0 0 0", m0_ack_o, m1_ack_o, s_cyc_o);
    else n_pass++;
    tick();
    force_ack = 1'b0;
    ack_en = 1'b1;
    wait_any_ack(got);
    n_total++;
    if (!got || m1_ack_o !== 1'b1) $display("FAIL abort_next: got=%0b m1_ack=%0b, required 1 1", got, m1_ack_o);
    else n_pass++;
    tick();
    idle_masters();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req(1'b0, 10'h00A);
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (outs_zero() !== 1'b1) $display("FAIL rstmid_during: s_cyc=%0b s_stb=%0b, required all outputs 0", s_cyc_o, s_stb_o);
    else n_pass++;
    tick();
    rst_i = 1'b0;
    force_ack = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (outs_zero() !== 1'b1) $display("FAIL rstmid_idle: s_cyc=%0b m0_ack=%0b, required all outputs 0", s_cyc_o, m0_ack_o);
    else n_pass++;
    tick();
    force_ack = 1'b0;
    idle_masters();
    repeat (3) tick();
  endtask

  initial begin
    rst_i = 1'b1; ack_en = 1'b1; force_ack = 1'b0;
    idle_masters();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_lock();
    test_watchdog();
    test_abort();
    test_reset_mid();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
